// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared font geometry, character codes and colour width for the text overlay
package vga_text_pkg;
  localparam int FONT_W = 8;
  localparam int FONT_H = 16;
  localparam int NUM_CHARS = 3;
  localparam int RGB_W = 12;
  typedef enum logic [1:0] {CH_BLANK = 2'd0, CH_I = 2'd1, CH_S = 2'd2, CH_A = 2'd3} char_code_t;
endpackage

// File: rtl/text_gen_if.sv
// text_gen_if: pixel stream in (pixel_x/y, video_on, syncs), font ROM link (rom_addr/rom_data), video out (rgb, syncs)
interface text_gen_if;
  import vga_text_pkg::*;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic video_on;
  logic hsync_in;
  logic vsync_in;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic [RGB_W-1:0] rgb;
  logic hsync_out;
  logic vsync_out;
  modport master (output pixel_x, pixel_y, video_on, hsync_in, vsync_in, rom_data, input rom_addr, rgb, hsync_out, vsync_out);
  modport slave (input pixel_x, pixel_y, video_on, hsync_in, vsync_in, rom_data, output rom_addr, rgb, hsync_out, vsync_out);
endinterface

// File: rtl/sync_delay.sv
// sync_delay: DEPTH-stage 1-bit shift register; ports clk, reset_n (async active-low), d in, q out
module sync_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr_q, sr_d;
  always_comb sr_d = DEPTH'({sr_q, d});
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sr_q <= '0;
    else sr_q <= sr_d;
  assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/text_gen.sv
// text_gen: 3-stage pipeline overlaying a 3-character text box on a pixel stream via an external font ROM.
// Ports: clk, reset_n (async active-low), bus (text_gen_if.slave). Optional TEXT_GEN_BLINK_EN: 64-frame blink.
module text_gen import vga_text_pkg::*; #(
  parameter logic [9:0] TEXT_X0 = 10'd308,
  parameter logic [9:0] TEXT_Y0 = 10'd232,
  parameter logic [RGB_W-1:0] FG_COLOR = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_COLOR = 12'h000
) (
  input logic clk,
  input logic reset_n,
  text_gen_if.slave bus
);
  localparam logic [10:0] X0 = 11'(TEXT_X0);
  localparam logic [10:0] Y0 = 11'(TEXT_Y0);
  localparam logic [10:0] BOX_W = 11'(FONT_W * NUM_CHARS);
  localparam logic [10:0] BOX_H = 11'(FONT_H);
  logic [10:0] px, py;
  logic [4:0] dx;
  logic [3:0] dy;
  logic in_box, in_box2, von2, vs1, hide, pix_on;
  logic [5:0] rom_addr_q, rom_addr_d;
  logic [2:0] col1_q, col1_d, col2_q, col2_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  // Out-of-box subtraction results are don't-care: the address is forced to the blank glyph.
  always_comb begin
    px = {1'b0, bus.pixel_x};
    py = {1'b0, bus.pixel_y};
    dx = 5'(bus.pixel_x - TEXT_X0);
    dy = 4'(bus.pixel_y - TEXT_Y0);
    in_box = px >= X0 && px < X0 + BOX_W && py >= Y0 && py < Y0 + BOX_H;
    rom_addr_d = in_box ? {dx[4:3] + 2'd1, dy} : {CH_BLANK, 4'h0};
    col1_d = dx[2:0];
    col2_d = col1_q;
    pix_on = in_box2 && bus.rom_data[3'd7 - col2_q] && !hide;
    rgb_d = !von2 ? '0 : pix_on ? FG_COLOR : BG_COLOR;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rom_addr_q <= '0;
      col1_q <= '0;
      col2_q <= '0;
      rgb_q <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      col1_q <= col1_d;
      col2_q <= col2_d;
      rgb_q <= rgb_d;
    end
  sync_delay #(.DEPTH(3)) u_hs (.clk(clk), .reset_n(reset_n), .d(bus.hsync_in), .q(bus.hsync_out));
  sync_delay #(.DEPTH(1)) u_vs1 (.clk(clk), .reset_n(reset_n), .d(bus.vsync_in), .q(vs1));
  sync_delay #(.DEPTH(2)) u_vs3 (.clk(clk), .reset_n(reset_n), .d(vs1), .q(bus.vsync_out));
  sync_delay #(.DEPTH(2)) u_box (.clk(clk), .reset_n(reset_n), .d(in_box), .q(in_box2));
  sync_delay #(.DEPTH(2)) u_von (.clk(clk), .reset_n(reset_n), .d(bus.video_on), .q(von2));
`ifdef TEXT_GEN_BLINK_EN
  // Frame counter advances on each falling edge of the stage-1 vsync; bit 5 hides the text.
  logic [5:0] blink_q, blink_d;
  logic vs_prev_q, vs_prev_d;
  always_comb begin
    vs_prev_d = vs1;
    blink_d = blink_q + 6'(vs_prev_q & ~vs1);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      blink_q <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      vs_prev_q <= vs_prev_d;
    end
  assign hide = blink_q[5];
`else
  assign hide = 1'b0;
`endif
  assign bus.rom_addr = rom_addr_q;
  assign bus.rgb = rgb_q;
endmodule

// File: tb/tb_text_gen.sv
// tb_text_gen: directed self-checking bench for text_gen with a registered font ROM model
module tb_text_gen;
  localparam logic [11:0] FG = 12'hF80;
  localparam logic [11:0] BG = 12'h01E;
  typedef struct {
    logic [11:0] rgb;
    logic hs;
    logic vs;
    string tag;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;
  exp_t q[$];
  logic [5:0] a_exp;
  logic a_chk = 1'b0;
  string a_tag;
  text_gen_if bus ();
  text_gen #(.FG_COLOR(FG), .BG_COLOR(BG)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] font(input logic [5:0] a);
    case (a)
      6'h11: return 8'hFE;
      6'h21: return 8'h7E;
      6'h31: return 8'h10;
      6'h15: return 8'h38;
      default: return 8'h00;
    endcase
  endfunction
  always_ff @(posedge clk) bus.rom_data <= font(bus.rom_addr);
  function automatic logic [11:0] row1_rgb(input int x);
    logic [23:0] pat;
    pat = 24'hFE7E10;
    return pat[23 - (x - 308)] ? FG : BG;
  endfunction
  function automatic logic [5:0] row1_addr(input int x);
    return 6'(((x - 308) / 8 + 1) * 16 + 1);
  endfunction
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_out();
    exp_t e;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk({e.tag, " rgb"}, bus.rgb, e.rgb);
      chk({e.tag, " hsync"}, 12'(bus.hsync_out), 12'(e.hs));
      chk({e.tag, " vsync"}, 12'(bus.vsync_out), 12'(e.vs));
    end
    if (a_chk) chk({a_tag, " rom_addr"}, 12'(bus.rom_addr), 12'(a_exp));
  endtask
  task automatic step(input int x, input int y, input logic von, input logic hs, input logic vs,
                      input logic [11:0] e_rgb, input logic [5:0] e_addr, input string tag);
    exp_t e;
    @(negedge clk);
    check_out();
    bus.pixel_x = 10'(x);
    bus.pixel_y = 10'(y);
    bus.video_on = von;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    e.rgb = e_rgb;
    e.hs = hs;
    e.vs = vs;
    e.tag = tag;
    q.push_back(e);
    a_exp = e_addr;
    a_chk = 1'b1;
    a_tag = tag;
  endtask
  initial begin
    bus.pixel_x = '0;
    bus.pixel_y = '0;
    bus.video_on = 1'b0;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    #1;
    chk("reset rgb", bus.rgb, 12'h000);
    chk("reset rom_addr", 12'(bus.rom_addr), 12'h000);
    chk("reset hsync_out", 12'(bus.hsync_out), 12'h000);
    chk("reset vsync_out", 12'(bus.vsync_out), 12'h000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    step(308, 232, 1, 0, 0, BG, 6'h10, "origin");
    step(310, 237, 1, 0, 0, FG, 6'h15, "I_row5");
    step(307, 233, 1, 0, 0, BG, 6'h00, "left_out");
    step(332, 233, 1, 0, 0, BG, 6'h00, "right_out");
    step(310, 248, 1, 0, 0, BG, 6'h00, "below_out");
    step(310, 231, 1, 0, 0, BG, 6'h00, "above_out");
    step(309, 233, 0, 0, 0, 12'h000, 6'h11, "video_off");
    step(0, 0, 0, 1, 1, 12'h000, 6'h00, "sync_pulse");
    step(0, 0, 0, 0, 0, 12'h000, 6'h00, "sync_after1");
    step(0, 0, 0, 0, 0, 12'h000, 6'h00, "sync_after2");
    step(0, 0, 0, 0, 0, 12'h000, 6'h00, "sync_after3");
    for (int x = 308; x < 332; x++) step(x, 233, 1, 0, 0, row1_rgb(x), row1_addr(x), $sformatf("sweep x=%0d", x));
    step(0, 0, 1, 0, 0, BG, 6'h00, "wrap");
    for (int x = 308; x < 314; x++) step(x, 233, 1, 0, 0, row1_rgb(x), row1_addr(x), $sformatf("pre_rst x=%0d", x));
    @(negedge clk);
    check_out();
    reset_n = 1'b0;
    #1;
    chk("async_rst rgb", bus.rgb, 12'h000);
    chk("async_rst rom_addr", 12'(bus.rom_addr), 12'h000);
    q.delete();
    a_chk = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int x = 314; x < 332; x++) step(x, 233, 1, 0, 0, row1_rgb(x), row1_addr(x), $sformatf("post_rst x=%0d", x));
`ifdef TEXT_GEN_BLINK_EN
    for (int f = 0; f < 31; f++) begin
      step(0, 0, 0, 0, 1, 12'h000, 6'h00, "frame_vs");
      step(0, 0, 0, 0, 0, 12'h000, 6'h00, "frame_gap");
    end
    step(309, 233, 1, 0, 0, FG, 6'h11, "blink_f31");
    step(0, 0, 0, 0, 1, 12'h000, 6'h00, "frame_vs");
    step(0, 0, 0, 0, 0, 12'h000, 6'h00, "frame_gap");
    step(309, 233, 1, 0, 0, BG, 6'h11, "blink_f32");
    for (int f = 0; f < 32; f++) begin
      step(0, 0, 0, 0, 1, 12'h000, 6'h00, "frame_vs");
      step(0, 0, 0, 0, 0, 12'h000, 6'h00, "frame_gap");
    end
    step(309, 233, 1, 0, 0, FG, 6'h11, "blink_f64");
`endif
    repeat (4) step(0, 0, 0, 0, 0, 12'h000, 6'h00, "drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
